// File: rtl/io_access_ctrl.sv
// Data-port access sequencer: decodes the memory-mapped region map, steers accesses to the
// cache, text VMEM, timer, keyboard or loader BRAM, and owns the millisecond timer.
module io_access_ctrl #(
    parameter int VGA_WR_CYCLES = 2,
    parameter int CLK_DIV       = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_read_in,
    input  logic        dmem_write_in,
    input  logic [29:0] dmem_addr,
    input  logic [31:0] data_from_reg,
    input  logic [3:0]  dmem_byte_w_en,
    output logic        io_stall,
    output logic [31:0] dmem_data_out,
    output logic        dc_read_out,
    output logic        dc_write_out,
    input  logic [31:0] dc_data_in,
    input  logic        cache_stall,
    output logic        vga_wen,
    output logic [14:0] vga_addr,
    output logic [7:0]  char_to_vga,
    output logic        loader_en,
    output logic        loader_wen,
    input  logic [31:0] loader_data,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_code,
    output logic        kbd_ack
);

    localparam int CNT_W = (VGA_WR_CYCLES > 1) ? $clog2(VGA_WR_CYCLES) : 1;
    localparam int PRE_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(VGA_WR_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_DIV - 1);

    localparam logic [3:0] REG_VGA = 4'hC;
    localparam logic [3:0] REG_TMR = 4'hD;
    localparam logic [3:0] REG_KBD = 4'hE;
    localparam logic [3:0] REG_LDR = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VGA_WR = 2'd1,
        ST_LD_RD  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       rdata_r;
    logic [31:0]       timer_ms_r;
    logic [PRE_W-1:0]  presc_r;

    logic              wr_s;
    logic              rd_s;
    logic [3:0]        region_s;
    logic [1:0]        lane_s;
    logic [7:0]        char_s;
    logic              timer_wr_s;
    logic              unused_addr_s;

    assign unused_addr_s = ^dmem_addr[25:13];

    // Request qualification: requests are ignored while in reset, write wins over read.
    always_comb begin
        wr_s       = rst & dmem_write_in;
        rd_s       = rst & dmem_read_in & ~dmem_write_in;
        region_s   = dmem_addr[29:26];
        timer_wr_s = (state_r == ST_IDLE) && (region_s == REG_TMR) && wr_s;
    end

    // Byte-lane to VMEM lane/char mapping; odd enable patterns fall back to the last lane.
    always_comb begin
        lane_s = 2'd3;
        char_s = data_from_reg[31:24];
        case (dmem_byte_w_en)
            4'b1000: begin lane_s = 2'd0; char_s = data_from_reg[7:0];   end
            4'b0100: begin lane_s = 2'd1; char_s = data_from_reg[15:8];  end
            4'b0010: begin lane_s = 2'd2; char_s = data_from_reg[23:16]; end
            default: begin lane_s = 2'd3; char_s = data_from_reg[31:24]; end
        endcase
    end

    // Combinational stall, read data and single-cycle device/cache strobes.
    always_comb begin
        io_stall      = 1'b0;
        dmem_data_out = 32'h0000_0000;
        dc_read_out   = 1'b0;
        dc_write_out  = 1'b0;
        loader_en     = 1'b0;
        loader_wen    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                case (region_s)
                    REG_VGA: io_stall = wr_s;
                    REG_TMR: dmem_data_out = rd_s ? timer_ms_r : 32'h0000_0000;
                    REG_KBD: io_stall = rd_s;
                    REG_LDR: begin
                        loader_en  = rd_s | wr_s;
                        loader_wen = wr_s;
                        io_stall   = rd_s;
                    end
                    default: begin
                        dc_read_out   = rd_s;
                        dc_write_out  = wr_s;
                        io_stall      = rst & cache_stall;
                        dmem_data_out = rst ? dc_data_in : 32'h0000_0000;
                    end
                endcase
            end
            ST_VGA_WR: io_stall = rst;
            ST_LD_RD:  io_stall = rst;
            ST_DONE:   dmem_data_out = rst ? rdata_r : 32'h0000_0000;
            default:   io_stall = 1'b0;
        endcase
    end

    // Access FSM with registered VMEM port, read-data latch and keyboard pop pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            rdata_r     <= 32'h0000_0000;
            vga_wen     <= 1'b0;
            vga_addr    <= 15'h0000;
            char_to_vga <= 8'h00;
            kbd_ack     <= 1'b0;
        end else begin
            kbd_ack <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if ((region_s == REG_VGA) && wr_s) begin
                        vga_addr    <= {dmem_addr[12:0], lane_s};
                        char_to_vga <= char_s;
                        cnt_r       <= CNT_LOAD;
                        vga_wen     <= 1'b1;
                        state_r     <= ST_VGA_WR;
                    end else if ((region_s == REG_LDR) && rd_s) begin
                        state_r <= ST_LD_RD;
                    end else if ((region_s == REG_KBD) && rd_s) begin
                        rdata_r <= {23'h000000, kbd_valid, kbd_code};
                        kbd_ack <= kbd_valid;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_VGA_WR: begin
                    if (cnt_r == '0) begin
                        vga_wen <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                ST_LD_RD: begin
                    rdata_r <= loader_data;
                    state_r <= ST_DONE;
                end
                ST_DONE: state_r <= ST_IDLE;
                default: begin
                    vga_wen <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Millisecond timer: a CPU write overrides a coincident prescaler wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timer_ms_r <= 32'h0000_0000;
            presc_r    <= '0;
        end else if (timer_wr_s) begin
            timer_ms_r <= data_from_reg;
            presc_r    <= '0;
        end else if (presc_r == PRE_MAX) begin
            timer_ms_r <= timer_ms_r + 32'd1;
            presc_r    <= '0;
        end else begin
            presc_r <= presc_r + 1'b1;
        end
    end

endmodule

// File: tb/tb_io_access_ctrl.sv
// Directed bench for io_access_ctrl with a small loader BRAM model and a fast timer.
module tb_io_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_read_in;
    logic        dmem_write_in;
    logic [29:0] dmem_addr;
    logic [31:0] data_from_reg;
    logic [3:0]  dmem_byte_w_en;
    logic        io_stall;
    logic [31:0] dmem_data_out;
    logic        dc_read_out;
    logic        dc_write_out;
    logic [31:0] dc_data_in;
    logic        cache_stall;
    logic        vga_wen;
    logic [14:0] vga_addr;
    logic [7:0]  char_to_vga;
    logic        loader_en;
    logic        loader_wen;
    logic [31:0] loader_data = 32'h0000_0000;
    logic        kbd_valid;
    logic [7:0]  kbd_code;
    logic        kbd_ack;

    logic [31:0] lmem [0:63];
    int tests = 0;
    int fails = 0;

    io_access_ctrl #(.VGA_WR_CYCLES(2), .CLK_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .dmem_read_in(dmem_read_in), .dmem_write_in(dmem_write_in),
        .dmem_addr(dmem_addr), .data_from_reg(data_from_reg),
        .dmem_byte_w_en(dmem_byte_w_en), .io_stall(io_stall),
        .dmem_data_out(dmem_data_out), .dc_read_out(dc_read_out),
        .dc_write_out(dc_write_out), .dc_data_in(dc_data_in),
        .cache_stall(cache_stall), .vga_wen(vga_wen), .vga_addr(vga_addr),
        .char_to_vga(char_to_vga), .loader_en(loader_en), .loader_wen(loader_wen),
        .loader_data(loader_data), .kbd_valid(kbd_valid), .kbd_code(kbd_code),
        .kbd_ack(kbd_ack)
    );

    always #5 clk = ~clk;

    // Loader BRAM: one-cycle registered read, write-enable qualified by port select.
    always @(posedge clk) begin
        if (loader_en) begin
            if (loader_wen) lmem[dmem_addr[5:0]] <= data_from_reg;
            loader_data <= lmem[dmem_addr[5:0]];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        dmem_read_in  = 1'b0;
        dmem_write_in = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) lmem[i] = 32'h0000_0000;
        rst = 1'b0; idle_bus();
        dmem_addr = 30'h0; data_from_reg = 32'h0; dmem_byte_w_en = 4'b0000;
        dc_data_in = 32'h0; cache_stall = 1'b0; kbd_valid = 1'b0; kbd_code = 8'h00;
        cyc(); cyc();

        // reset state, request ignored during reset
        dmem_write_in = 1'b1; dmem_addr = 30'h3000_0005; #1;
        chk("rst_stall", io_stall, 32'd0);
        chk("rst_wen", vga_wen, 32'd0);
        chk("rst_vaddr", vga_addr, 32'd0);
        chk("rst_char", char_to_vga, 32'd0);
        chk("rst_ack", kbd_ack, 32'd0);
        chk("rst_dout", dmem_data_out, 32'd0);
        idle_bus();
        cyc(); rst = 1'b1; cyc();

        // VMEM store: lane 1, char 0x41
        dmem_write_in = 1'b1; dmem_addr = 30'h3000_0005;
        dmem_byte_w_en = 4'b0100; data_from_reg = 32'h0000_4100; #1;
        chk("vga_idle_stall", io_stall, 32'd1);
        chk("vga_idle_wen", vga_wen, 32'd0);
        cyc();
        chk("vga_w1_stall", io_stall, 32'd1);
        chk("vga_w1_wen", vga_wen, 32'd1);
        chk("vga_addr", vga_addr, 32'h0015);
        chk("vga_char", char_to_vga, 32'h41);
        cyc();
        chk("vga_w2_stall", io_stall, 32'd1);
        chk("vga_w2_wen", vga_wen, 32'd1);
        cyc();
        chk("vga_done_stall", io_stall, 32'd0);
        chk("vga_done_wen", vga_wen, 32'd0);
        chk("vga_hold_addr", vga_addr, 32'h0015);
        idle_bus(); cyc();
        chk("vga_after_wen", vga_wen, 32'd0);

        // VMEM store with a non-one-hot enable maps to lane 3
        dmem_write_in = 1'b1; dmem_addr = 30'h3000_1FFF;
        dmem_byte_w_en = 4'b0011; data_from_reg = 32'h5A00_0000;
        cyc();
        chk("vga_l3_addr", vga_addr, 32'h7FFF);
        chk("vga_l3_char", char_to_vga, 32'h5A);
        cyc(); cyc(); idle_bus(); cyc();

        // VMEM read returns zero, no stall
        dmem_read_in = 1'b1; dmem_addr = 30'h3000_0005; #1;
        chk("vga_rd_stall", io_stall, 32'd0);
        chk("vga_rd_data", dmem_data_out, 32'd0);
        idle_bus(); cyc();

        // reset in the 2nd VGA_WR cycle
        dmem_write_in = 1'b1; dmem_addr = 30'h3000_0002;
        dmem_byte_w_en = 4'b1000; data_from_reg = 32'h0000_0077;
        cyc();
        chk("rwr_addr", vga_addr, 32'h0008);
        chk("rwr_char", char_to_vga, 32'h77);
        cyc();
        chk("rwr_w2_wen", vga_wen, 32'd1);
        rst = 1'b0; #1;
        chk("rwr_rst_stall", io_stall, 32'd0);
        cyc();
        chk("rwr_wen", vga_wen, 32'd0);
        chk("rwr_vaddr", vga_addr, 32'd0);
        chk("rwr_stall_inrst", io_stall, 32'd0);
        rst = 1'b1; #1;
        chk("rwr_stall_new", io_stall, 32'd1);
        idle_bus(); cyc();
        chk("rwr_idle_wen", vga_wen, 32'd0);

        // loader write then read back
        dmem_write_in = 1'b1; dmem_addr = 30'h3C00_0010; data_from_reg = 32'hDEAD_BEEF; #1;
        chk("ldw_en", loader_en, 32'd1);
        chk("ldw_wen", loader_wen, 32'd1);
        chk("ldw_stall", io_stall, 32'd0);
        cyc(); idle_bus(); data_from_reg = 32'h0; #1;
        chk("ldw_after_wen", loader_wen, 32'd0);
        dmem_read_in = 1'b1; #1;
        chk("ldr_idle_stall", io_stall, 32'd1);
        chk("ldr_idle_en", loader_en, 32'd1);
        chk("ldr_idle_wen", loader_wen, 32'd0);
        cyc();
        chk("ldr_ld_stall", io_stall, 32'd1);
        chk("ldr_ld_en", loader_en, 32'd0);
        cyc();
        chk("ldr_done_stall", io_stall, 32'd0);
        chk("ldr_done_data", dmem_data_out, 32'hDEAD_BEEF);
        idle_bus(); cyc();

        // keyboard reads with and without a pending code
        kbd_valid = 1'b1; kbd_code = 8'h1C; dmem_read_in = 1'b1; dmem_addr = 30'h3800_0000; #1;
        chk("kbd_idle_stall", io_stall, 32'd1);
        chk("kbd_idle_ack", kbd_ack, 32'd0);
        cyc();
        chk("kbd_done_stall", io_stall, 32'd0);
        chk("kbd_done_data", dmem_data_out, 32'h0000_011C);
        chk("kbd_done_ack", kbd_ack, 32'd1);
        idle_bus(); cyc();
        chk("kbd_ack_drop", kbd_ack, 32'd0);
        kbd_valid = 1'b0; kbd_code = 8'h00; dmem_read_in = 1'b1;
        cyc();
        chk("kbd_empty_data", dmem_data_out, 32'd0);
        chk("kbd_empty_ack", kbd_ack, 32'd0);
        idle_bus(); cyc();
        dmem_write_in = 1'b1; #1;
        chk("kbd_wr_stall", io_stall, 32'd0);
        idle_bus(); cyc();

        // back-to-back keyboard reads separated by one DONE cycle
        kbd_valid = 1'b1; kbd_code = 8'h55; dmem_read_in = 1'b1; #1;
        chk("b2b_s0", io_stall, 32'd1);
        cyc();
        chk("b2b_s1", io_stall, 32'd0);
        chk("b2b_ack1", kbd_ack, 32'd1);
        cyc();
        chk("b2b_s2", io_stall, 32'd1);
        chk("b2b_ack2", kbd_ack, 32'd0);
        cyc();
        chk("b2b_s3", io_stall, 32'd0);
        chk("b2b_data", dmem_data_out, 32'h0000_0155);
        idle_bus(); kbd_valid = 1'b0; cyc();

        // timer wrap: write 0xFFFFFFFE, ticks every 4 cycles
        dmem_write_in = 1'b1; dmem_addr = 30'h3400_0000; data_from_reg = 32'hFFFF_FFFE; #1;
        chk("tmr_wr_stall", io_stall, 32'd0);
        cyc(); idle_bus();
        dmem_read_in = 1'b1; #1;
        chk("tmr_loaded", dmem_data_out, 32'hFFFF_FFFE);
        chk("tmr_rd_stall", io_stall, 32'd0);
        cyc(); cyc(); cyc(); cyc();
        chk("tmr_tick1", dmem_data_out, 32'hFFFF_FFFF);
        cyc(); cyc(); cyc(); cyc();
        chk("tmr_wrap", dmem_data_out, 32'h0000_0000);

        // timer write coinciding with a tick: write value wins
        cyc(); cyc(); cyc();
        dmem_read_in = 1'b0; dmem_write_in = 1'b1; data_from_reg = 32'h1234_5678;
        cyc();
        idle_bus(); dmem_read_in = 1'b1; #1;
        chk("tmr_wr_wins", dmem_data_out, 32'h1234_5678);
        cyc(); cyc(); cyc();
        chk("tmr_presc_clr", dmem_data_out, 32'h1234_5678);
        cyc();
        chk("tmr_next_tick", dmem_data_out, 32'h1234_5679);
        idle_bus(); cyc();

        // cache pass-through with a 10-cycle cache stall
        dmem_read_in = 1'b1; dmem_addr = 30'h0000_0040;
        cache_stall = 1'b1; dc_data_in = 32'hCAFE_F00D; #1;
        chk("dc_rd", dc_read_out, 32'd1);
        chk("dc_wr", dc_write_out, 32'd0);
        chk("dc_data", dmem_data_out, 32'hCAFE_F00D);
        for (int i = 0; i < 10; i++) begin
            chk("dc_stall_hi", io_stall, 32'd1);
            cyc();
        end
        cache_stall = 1'b0; dc_data_in = 32'h0BAD_C0DE; #1;
        chk("dc_stall_lo", io_stall, 32'd0);
        chk("dc_data2", dmem_data_out, 32'h0BAD_C0DE);
        dmem_write_in = 1'b1; #1;
        chk("dc_wwins_wr", dc_write_out, 32'd1);
        chk("dc_wwins_rd", dc_read_out, 32'd0);
        idle_bus(); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
